// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - round-robin arbiter sharing one 16x32 signed saturating multiplier
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     per-requester handshake (NREQ bits), req_ready is the grant
//   req_a                   NREQ x 16-bit signed coefficients, requester i at [16i+15:16i]
//   req_x                   NREQ x 32-bit signed operands, requester i at [32i+31:32i]
//   out_valid/out_ready     result handshake
//   out_data, out_id        saturated product and the requester that produced it
//   out_sat                 out_data was clamped
//   sat_clr, sat_cnt        saturation counter clear / value
//
// Optional feature: define MUL_ARB_SATCNT_EN to build the saturation counter;
// otherwise sat_cnt is tied to 0 and sat_clr is ignored.
module mul_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*16-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_x,
    output logic [NREQ-1:0]      req_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic [IDW-1:0]       out_id,
    output logic                 out_sat,
    input  logic                 sat_clr,
    output logic [15:0]          sat_cnt
);

    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        out_data_q, out_data_d;
    logic [IDW-1:0]     out_id_q, out_id_d;
    logic               out_sat_q, out_sat_d;

    logic               slot_free;
    logic               gnt_found;
    logic [IDW-1:0]     gnt_idx;
    logic [IDW-1:0]     cand;
    logic               xfer;

    logic [15:0]        a_sel;
    logic [31:0]        x_sel;
    logic signed [47:0] prod;
    logic               ovf;
    logic [31:0]        sat_data;

    assign slot_free = !out_valid_q || out_ready;

    // Round-robin search; NREQ is a power of two so the IDW-bit add wraps modulo NREQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = rr_ptr_q + IDW'(k);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign xfer = gnt_found && slot_free;

    // Grant is masked by rst_n so it reads 0 while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && xfer) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign a_sel = req_a[16*gnt_idx +: 16];
    assign x_sel = req_x[32*gnt_idx +: 32];

    // Both operands sign-extended to 48 bits; the exact product fits in 48 bits.
    assign prod = $signed({{32{a_sel[15]}}, a_sel}) * $signed({{16{x_sel[31]}}, x_sel});

    // Result fits in 32 bits only when bits [47:31] are all copies of the sign.
    assign ovf      = !((&prod[47:31]) || !(|prod[47:31]));
    assign sat_data = ovf ? (prod[47] ? 32'h8000_0000 : 32'h7FFF_FFFF) : prod[31:0];

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        out_sat_d   = out_sat_q;
        if (xfer) begin
            rr_ptr_d    = gnt_idx + IDW'(1);
            out_valid_d = 1'b1;
            out_data_d  = sat_data;
            out_id_d    = gnt_idx;
            out_sat_d   = ovf;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign out_sat   = out_sat_q;

`ifdef MUL_ARB_SATCNT_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;

    // Clear has priority over a same-cycle saturating transfer; count sticks at max.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_clr) begin
            sat_cnt_d = '0;
        end else if (xfer && ovf && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_cnt = sat_cnt_q;
`else
    logic unused_sat_clr;
    assign unused_sat_clr = sat_clr;
    assign sat_cnt        = '0;
`endif

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter NREQ, default 4, is the number of requesters; legal values are 2, 4 and 8.
REQ-002 Parameter IDW, default 2, is the requester ID width; it SHALL equal log2(NREQ).
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL update on the rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port req_valid, input, NREQ bits: bit i means requester i presents an operand pair.
REQ-006 Port req_a, input, NREQ*16 bits: signed coefficient; requester i uses bits [16i+15:16i].
REQ-007 Port req_x, input, NREQ*32 bits: signed operand; requester i uses bits [32i+31:32i].
REQ-008 Port req_ready, output, NREQ bits: grant; at most one bit SHALL be high in any cycle.
REQ-009 Port out_valid, output, 1 bit: a result is held on the output.
REQ-010 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 Port out_data, output, 32 bits: saturated signed product.
REQ-012 Port out_id, output, IDW bits: index of the requester that produced out_data.
REQ-013 Port out_sat, output, 1 bit: out_data was clamped.
REQ-014 Port sat_clr, input, 1 bit: synchronous clear of sat_cnt.
REQ-015 Port sat_cnt, output, 16 bits: count of saturated results.

Function
REQ-016 The block SHALL share one 16x32 signed saturating multiplier among NREQ requesters and register its result in a single output stage.
REQ-017 The output slot is free when out_valid==0 or out_ready==1; arbitration SHALL occur only when the slot is free.
REQ-018 Arbitration SHALL be round-robin: search starts at rr_ptr and takes the first index with req_valid set, counting upward modulo NREQ.
REQ-019 req_ready[g] SHALL be 1 only for the winner g, and only while the slot is free; it is combinational from req_valid, rr_ptr, out_valid and out_ready.
REQ-020 A transfer is req_valid[g] & req_ready[g]; on a transfer rr_ptr SHALL become (g+1) mod NREQ; otherwise rr_ptr SHALL hold.
REQ-021 Latency SHALL be 1 cycle: on a transfer, out_valid, out_data, out_id and out_sat load on the same edge.
REQ-022 Product p = signed(a) * signed(x), 48-bit exact; out_data = p when -2^31 <= p <= 2^31-1.
REQ-023 If p > 2^31-1, out_data SHALL be 0x7FFFFFFF and out_sat 1; if p < -2^31, out_data SHALL be 0x80000000 and out_sat 1; otherwise out_sat is 0.
REQ-024 While out_valid==1 and out_ready==0, out_data, out_id and out_sat SHALL hold stable and all req_ready bits SHALL be 0.
REQ-025 out_valid SHALL clear when out_ready==1 and no transfer occurs in that cycle; a drain and a new transfer in the same cycle SHALL give back-to-back results (full throughput).
REQ-026 A requester SHALL keep req_valid and its operands stable until granted; the block SHALL NOT drop or duplicate a request.

Reset
REQ-027 rst_n low SHALL asynchronously force out_valid=0, out_data=0, out_id=0, out_sat=0, rr_ptr=0 and sat_cnt=0, and req_ready SHALL read 0 while reset is asserted.
REQ-028 Reset asserted mid-operation SHALL discard the held result without emitting it; operation resumes on the first edge after rst_n is released.

Configuration
REQ-029 Macro MUL_ARB_SATCNT_EN defined: sat_cnt SHALL increment by 1 on each transfer whose result saturates, stick at 0xFFFF, and clear to 0 on sat_clr; when sat_clr and a saturating transfer occur in the same cycle, sat_clr wins and the count becomes 0.
REQ-030 Macro MUL_ARB_SATCNT_EN undefined: sat_cnt SHALL be the constant 0, sat_clr is ignored, and no counter register is built.

Verification
REQ-031 Set a0=0x0002, x0=0x00001000 with req_valid=0001 and out_ready=1 -> next cycle out_valid=1, out_data=0x00002000, out_id=0, out_sat=0.
REQ-032 Set a=0x7FFF, x=0x7FFFFFFF -> out_data=0x7FFFFFFF, out_sat=1; set a=0x8000, x=0x7FFFFFFF -> out_data=0x80000000, out_sat=1; set a=0xFFFF, x=0x80000000 -> out_data=0x7FFFFFFF, out_sat=1.
REQ-033 Hold all four req_valid=1 with out_ready=1 -> grants follow 0,1,2,3,0 on consecutive cycles, out_valid stays 1, and the out_id sequence matches.
REQ-034 Hold out_ready=0 for 5 cycles with a result held -> req_ready=0 and outputs stable; raise out_ready -> the next grant is issued in that same cycle.
REQ-035 With MUL_ARB_SATCNT_EN defined, issue 3 saturating results -> sat_cnt=3; then assert sat_clr together with a saturating transfer -> sat_cnt=0; force the count to 0xFFFF and issue another saturating result -> it stays 0xFFFF.
REQ-036 Assert rst_n low while out_valid=1 and out_ready=0 -> all outputs are 0 immediately, without waiting for a clock edge, and no stale result appears after release.
